// File: rtl/remote_comm_if.sv
// Host command/response bundle for remote_comm: command strobe, UART pins and response flags.
// The master side belongs to the host/bench, the slave side to remote_comm itself.
interface remote_comm_if;
    logic [15:0] cmd;
    logic        send_cmd;
    logic        cmd_sent;
    logic        busy;
    logic        TX;
    logic        RX;
    logic [7:0]  resp;
    logic        resp_rdy;
    logic        resp_timeout;

    modport master (
        output cmd, send_cmd, RX,
        input  cmd_sent, busy, TX, resp, resp_rdy, resp_timeout
    );

    modport slave (
        input  cmd, send_cmd, RX,
        output cmd_sent, busy, TX, resp, resp_rdy, resp_timeout
    );
endinterface

// File: rtl/remote_comm.sv
// Host-side UART command link: sends 16-bit commands as two 8N1 frames (high byte first) and
// receives one-byte responses. Optional response timeout enabled by REMOTE_COMM_RESP_TIMEOUT_EN.
module remote_comm #(
    parameter int          BAUD_DIV     = 5208,
    parameter logic [23:0] RESP_TIMEOUT = 24'hFF_FFFF
) (
    input  logic          clk,
    input  logic          RST_n,
    remote_comm_if.slave  bus
);
    localparam int             BW        = $clog2(BAUD_DIV) + 1;
    localparam logic [BW-1:0]  BAUD_MAX  = BW'(BAUD_DIV - 1);
    localparam logic [BW-1:0]  BAUD_HALF = BW'(BAUD_DIV / 2 - 1);

    typedef enum logic [2:0] {IDLE, LOAD_H, SEND_H, LOAD_L, SEND_L, DONE} tx_state_t;
    typedef enum logic       {RX_IDLE, RX_RECV} rx_state_t;

    tx_state_t      r_tx_state;
    tx_state_t      w_tx_next;
    logic [15:0]    r_cmd;
    logic [9:0]     r_tx_shift;
    logic [BW-1:0]  r_tx_baud;
    logic [3:0]     r_tx_bit;
    logic           r_tx;
    logic           r_busy;
    logic           r_cmd_sent;
    logic           w_accept;
    logic           w_tx_bit_end;
    logic           w_tx_frame_end;

    rx_state_t      r_rx_state;
    rx_state_t      w_rx_next;
    logic           r_sync1;
    logic           r_sync2;
    logic           r_sync3;
    logic [BW-1:0]  r_rx_baud;
    logic [3:0]     r_rx_cnt;
    logic [7:0]     r_rx_shift;
    logic [7:0]     r_resp;
    logic           r_resp_rdy;
    logic           w_rx_start;
    logic           w_rx_sample;
    logic           w_rx_good;

    assign w_accept       = (r_tx_state == IDLE) && bus.send_cmd;
    assign w_tx_bit_end   = (r_tx_baud == '0);
    assign w_tx_frame_end = w_tx_bit_end && (r_tx_bit == 4'd9);

    // TX next-state logic
    always_comb begin
        w_tx_next = r_tx_state;
        case (r_tx_state)
            IDLE: begin
                if (bus.send_cmd) w_tx_next = LOAD_H;
                else              w_tx_next = IDLE;
            end
            LOAD_H: w_tx_next = SEND_H;
            SEND_H: begin
                if (w_tx_frame_end) w_tx_next = LOAD_L;
                else                w_tx_next = SEND_H;
            end
            LOAD_L: w_tx_next = SEND_L;
            SEND_L: begin
                if (w_tx_frame_end) w_tx_next = DONE;
                else                w_tx_next = SEND_L;
            end
            DONE:    w_tx_next = IDLE;
            default: w_tx_next = IDLE;
        endcase
    end

    // TX state, frame shifter and registered line/status outputs
    always_ff @(posedge clk) begin
        if (!RST_n) begin
            r_tx_state <= IDLE;
            r_cmd      <= 16'h0000;
            r_tx_shift <= 10'h3FF;
            r_tx_baud  <= '0;
            r_tx_bit   <= 4'd0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_cmd_sent <= 1'b0;
        end else begin
            r_tx_state <= w_tx_next;
            r_busy     <= (w_tx_next != IDLE);
            r_cmd_sent <= (r_tx_state == DONE);
            if (w_accept) r_cmd <= bus.cmd;
            case (r_tx_state)
                LOAD_H: begin
                    r_tx_shift <= {1'b1, r_cmd[15:8], 1'b0};
                    r_tx_baud  <= BAUD_MAX;
                    r_tx_bit   <= 4'd0;
                    r_tx       <= 1'b1;
                end
                LOAD_L: begin
                    r_tx_shift <= {1'b1, r_cmd[7:0], 1'b0};
                    r_tx_baud  <= BAUD_MAX;
                    r_tx_bit   <= 4'd0;
                    r_tx       <= 1'b1;
                end
                SEND_H, SEND_L: begin
                    // TX lags the shifter by one cycle, which gives the N+2 start-bit latency
                    r_tx <= r_tx_shift[0];
                    if (w_tx_bit_end) begin
                        r_tx_baud  <= BAUD_MAX;
                        r_tx_shift <= {1'b1, r_tx_shift[9:1]};
                        r_tx_bit   <= r_tx_bit + 4'd1;
                    end else begin
                        r_tx_baud  <= r_tx_baud - BW'(1);
                    end
                end
                default: r_tx <= 1'b1;
            endcase
        end
    end

    assign w_rx_start  = (r_rx_state == RX_IDLE) && r_sync3 && !r_sync2;
    assign w_rx_sample = (r_rx_state == RX_RECV) && (r_rx_baud == '0);
    assign w_rx_good   = w_rx_sample && (r_rx_cnt == 4'd9) && r_sync2;

    // RX next-state logic: false start and end of frame both return to idle
    always_comb begin
        w_rx_next = r_rx_state;
        case (r_rx_state)
            RX_IDLE: begin
                if (w_rx_start) w_rx_next = RX_RECV;
                else            w_rx_next = RX_IDLE;
            end
            RX_RECV: begin
                if (w_rx_sample && (((r_rx_cnt == 4'd0) && r_sync2) || (r_rx_cnt == 4'd9)))
                    w_rx_next = RX_IDLE;
                else
                    w_rx_next = RX_RECV;
            end
            default: w_rx_next = RX_IDLE;
        endcase
    end

    // RX synchronizer, sampler and response register
    always_ff @(posedge clk) begin
        if (!RST_n) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_sync3    <= 1'b1;
            r_rx_state <= RX_IDLE;
            r_rx_baud  <= '0;
            r_rx_cnt   <= 4'd0;
            r_rx_shift <= 8'h00;
            r_resp     <= 8'h00;
            r_resp_rdy <= 1'b0;
        end else begin
            r_sync1    <= bus.RX;
            r_sync2    <= r_sync1;
            r_sync3    <= r_sync2;
            r_rx_state <= w_rx_next;
            if (w_rx_start) begin
                r_rx_baud <= BAUD_HALF;
                r_rx_cnt  <= 4'd0;
            end else if (r_rx_state == RX_RECV) begin
                if (r_rx_baud == '0) begin
                    r_rx_baud <= BAUD_MAX;
                    r_rx_cnt  <= r_rx_cnt + 4'd1;
                    if ((r_rx_cnt >= 4'd1) && (r_rx_cnt <= 4'd8))
                        r_rx_shift <= {r_sync2, r_rx_shift[7:1]};
                end else begin
                    r_rx_baud <= r_rx_baud - BW'(1);
                end
            end
            if (w_rx_good) begin
                r_resp     <= r_rx_shift;
                r_resp_rdy <= 1'b1;
            end else if (w_accept || w_rx_start) begin
                r_resp_rdy <= 1'b0;
            end
        end
    end

`ifdef REMOTE_COMM_RESP_TIMEOUT_EN
    logic [23:0] r_to_cnt;
    logic        r_to_run;
    logic        r_resp_timeout;

    // Response timeout: armed at cmd_sent, halted by a good byte, flag cleared by the next command
    always_ff @(posedge clk) begin
        if (!RST_n) begin
            r_to_cnt       <= 24'd0;
            r_to_run       <= 1'b0;
            r_resp_timeout <= 1'b0;
        end else if (w_accept) begin
            r_to_run       <= 1'b0;
            r_resp_timeout <= 1'b0;
        end else if (r_tx_state == DONE) begin
            r_to_cnt <= 24'd0;
            r_to_run <= 1'b1;
        end else if (w_rx_good) begin
            r_to_run <= 1'b0;
        end else if (r_to_run) begin
            r_to_cnt <= r_to_cnt + 24'd1;
            if ((r_to_cnt + 24'd1) == RESP_TIMEOUT) begin
                r_resp_timeout <= 1'b1;
                r_to_run       <= 1'b0;
            end
        end
    end

    assign bus.resp_timeout = r_resp_timeout;
`else
    assign bus.resp_timeout = 1'b0;
`endif

    assign bus.TX       = r_tx;
    assign bus.busy     = r_busy;
    assign bus.cmd_sent = r_cmd_sent;
    assign bus.resp     = r_resp;
    assign bus.resp_rdy = r_resp_rdy;
endmodule

// File: tb/tb_remote_comm.sv
// Self-checking bench for remote_comm with BAUD_DIV=16: TX waveform against a timing model,
// RX bytes with good/bad framing, full duplex, mid-operation reset and the optional timeout.
module tb_remote_comm;
    localparam int B = 16;
    localparam int L = 330;
    localparam int RXN = 10 * B + 4;

    logic clk = 1'b0;
    logic RST_n = 1'b0;
    always #5 clk = ~clk;

    remote_comm_if u_if();

    remote_comm #(.BAUD_DIV(B), .RESP_TIMEOUT(24'd1000)) dut (
        .clk   (clk),
        .RST_n (RST_n),
        .bus   (u_if)
    );

    int n_checks = 0;
    int n_pass = 0;
    logic [7:0] last_resp = 8'h00;

    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return b[k-1];
    endfunction

    // Expected TX level after edge N+c, where N is the accepting edge
    function automatic logic exp_tx(input logic [15:0] c16, input int c);
        if (c >= 2 && c < 2 + 10 * B) return frame_bit(c16[15:8], (c - 2) / B);
        if (c >= 3 + 10 * B && c < 3 + 20 * B) return frame_bit(c16[7:0], (c - 3 - 10 * B) / B);
        return 1'b1;
    endfunction

    task automatic tx_cmd(input logic [15:0] c16, input bit inject);
        logic tr_tx [0:L];
        logic tr_sent [0:L];
        logic tr_busy [0:L];
        logic tr_to0;
        int bad_tx, bad_busy, n_sent, pos_sent;
        @(negedge clk);
        u_if.cmd = c16;
        u_if.send_cmd = 1'b1;
        for (int c = 0; c <= L; c++) begin
            @(negedge clk);
            tr_tx[c] = u_if.TX;
            tr_sent[c] = u_if.cmd_sent;
            tr_busy[c] = u_if.busy;
            if (c == 0) tr_to0 = u_if.resp_timeout;
            if (inject && c == 49) begin
                u_if.cmd = 16'hFFFF;
                u_if.send_cmd = 1'b1;
            end else begin
                u_if.send_cmd = 1'b0;
            end
        end
        bad_tx = -1; bad_busy = -1; n_sent = 0; pos_sent = -1;
        for (int c = 0; c <= L; c++) begin
            if (bad_tx < 0 && tr_tx[c] !== exp_tx(c16, c)) bad_tx = c;
            if (bad_busy < 0 && tr_busy[c] !== (c < 323)) bad_busy = c;
            if (tr_sent[c] === 1'b1) begin
                n_sent++;
                pos_sent = c;
            end
        end
        n_checks++;
        if (bad_tx < 0) n_pass++;
        else $display("FAIL tx_wave cmd=%h cycle %0d: TX=%b expected %b", c16, bad_tx, tr_tx[bad_tx], exp_tx(c16, bad_tx));
        n_checks++;
        if (n_sent == 1 && pos_sent == 323) n_pass++;
        else $display("FAIL cmd_sent cmd=%h: %0d pulses, last at cycle %0d, expected 1 pulse at 323", c16, n_sent, pos_sent);
        n_checks++;
        if (bad_busy < 0) n_pass++;
        else $display("FAIL busy cmd=%h cycle %0d: busy=%b expected %b", c16, bad_busy, tr_busy[bad_busy], bad_busy < 323);
        n_checks++;
        if (tr_to0 === 1'b0) n_pass++;
        else $display("FAIL timeout_clear_on_accept: resp_timeout=%b expected 0", tr_to0);
    endtask

    task automatic rx_byte(input logic [7:0] b, input logic stop, input bit good);
        logic tr_rdy [0:RXN];
        logic [7:0] prev;
        int rise;
        prev = last_resp;
        for (int i = 0; i <= RXN; i++) begin
            @(negedge clk);
            if (i > 0) tr_rdy[i] = u_if.resp_rdy;
            if (i < 10 * B) begin
                if (i / B == 0)      u_if.RX = 1'b0;
                else if (i / B == 9) u_if.RX = stop;
                else                 u_if.RX = b[i / B - 1];
            end else begin
                u_if.RX = 1'b1;
            end
        end
        rise = -1;
        for (int i = 11; i <= RXN; i++)
            if (rise < 0 && tr_rdy[i] === 1'b1) rise = i;
        n_checks++;
        if (tr_rdy[10] === 1'b0) n_pass++;
        else $display("FAIL rdy_clear_on_start byte=%h: resp_rdy=%b expected 0", b, tr_rdy[10]);
        if (good) begin
            n_checks++;
            if (rise >= 154 && rise <= 156) n_pass++;
            else $display("FAIL rdy_latency byte=%h: rose at %0d expected 154..156", b, rise);
            n_checks++;
            if (u_if.resp === b && u_if.resp_rdy === 1'b1) n_pass++;
            else $display("FAIL resp_value: resp=%h rdy=%b expected %h rdy=1", u_if.resp, u_if.resp_rdy, b);
            last_resp = b;
        end else begin
            n_checks++;
            if (rise < 0 && u_if.resp === prev) n_pass++;
            else $display("FAIL framing_err byte=%h: rise=%0d resp=%h expected no rise resp=%h", b, rise, u_if.resp, prev);
        end
    endtask

    task automatic test_reset();
        int bad;
        RST_n = 1'b0;
        u_if.RX = 1'b1;
        u_if.send_cmd = 1'b0;
        u_if.cmd = 16'h0000;
        repeat (2) @(negedge clk);
        n_checks++; if (u_if.TX === 1'b1) n_pass++; else $display("FAIL reset_tx: %b expected 1", u_if.TX);
        n_checks++; if (u_if.busy === 1'b0) n_pass++; else $display("FAIL reset_busy: %b expected 0", u_if.busy);
        n_checks++; if (u_if.cmd_sent === 1'b0) n_pass++; else $display("FAIL reset_cmd_sent: %b expected 0", u_if.cmd_sent);
        n_checks++; if (u_if.resp === 8'h00) n_pass++; else $display("FAIL reset_resp: %h expected 00", u_if.resp);
        n_checks++; if (u_if.resp_rdy === 1'b0) n_pass++; else $display("FAIL reset_rdy: %b expected 0", u_if.resp_rdy);
        n_checks++; if (u_if.resp_timeout === 1'b0) n_pass++; else $display("FAIL reset_timeout: %b expected 0", u_if.resp_timeout);
        RST_n = 1'b1;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (u_if.TX !== 1'b1 || u_if.busy !== 1'b0) bad++;
        end
        n_checks++; if (bad == 0) n_pass++; else $display("FAIL idle_after_reset: %0d bad cycles expected 0", bad);
    endtask

    task automatic test_tx();
        tx_cmd(16'h2A5F, 1'b1);
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            tx_cmd(16'($urandom), bit'(k));
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic test_rx();
        rx_byte(8'hA5, 1'b1, 1'b1);
        rx_byte(8'h5A, 1'b1, 1'b1);
        for (int k = 0; k < 2; k++) rx_byte(8'($urandom), 1'b1, 1'b1);
        rx_byte(8'h3C, 1'b0, 1'b0);
        @(negedge clk);
        u_if.RX = 1'b0;
        repeat (4) @(negedge clk);
        u_if.RX = 1'b1;
        repeat (200) @(negedge clk);
        n_checks++;
        if (u_if.resp_rdy === 1'b0 && u_if.resp === last_resp) n_pass++;
        else $display("FAIL glitch: rdy=%b resp=%h expected rdy=0 resp=%h", u_if.resp_rdy, u_if.resp, last_resp);
    endtask

    task automatic test_full_duplex();
        logic [15:0] c16;
        logic [7:0] b;
        c16 = 16'($urandom);
        b = 8'($urandom);
        fork
            tx_cmd(c16, 1'b0);
            rx_byte(b, 1'b1, 1'b1);
        join
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int bad;
        @(negedge clk);
        u_if.cmd = 16'($urandom);
        u_if.send_cmd = 1'b1;
        @(negedge clk);
        u_if.send_cmd = 1'b0;
        repeat (40) @(negedge clk);
        RST_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if (u_if.TX === 1'b1 && u_if.busy === 1'b0 && u_if.resp === 8'h00 && u_if.resp_rdy === 1'b0) n_pass++;
        else $display("FAIL mid_reset: TX=%b busy=%b resp=%h rdy=%b expected 1 0 00 0", u_if.TX, u_if.busy, u_if.resp, u_if.resp_rdy);
        RST_n = 1'b1;
        last_resp = 8'h00;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (u_if.TX !== 1'b1 || u_if.busy !== 1'b0 || u_if.cmd_sent !== 1'b0) bad++;
        end
        n_checks++; if (bad == 0) n_pass++; else $display("FAIL post_reset_idle: %0d bad cycles expected 0", bad);
    endtask

    task automatic test_timeout();
`ifdef REMOTE_COMM_RESP_TIMEOUT_EN
        int bad;
        tx_cmd(16'($urandom), 1'b0);
        repeat (992) @(negedge clk);
        n_checks++; if (u_if.resp_timeout === 1'b0) n_pass++; else $display("FAIL timeout_early: %b expected 0", u_if.resp_timeout);
        repeat (2) @(negedge clk);
        n_checks++; if (u_if.resp_timeout === 1'b1) n_pass++; else $display("FAIL timeout_set: %b expected 1", u_if.resp_timeout);
        tx_cmd(16'($urandom), 1'b0);
        rx_byte(8'hA5, 1'b1, 1'b1);
        bad = 0;
        repeat (1000) begin
            @(negedge clk);
            if (u_if.resp_timeout !== 1'b0) bad++;
        end
        n_checks++; if (bad == 0) n_pass++; else $display("FAIL timeout_with_reply: %0d cycles set expected 0", bad);
`else
        int bad;
        tx_cmd(16'($urandom), 1'b0);
        bad = 0;
        repeat (1100) begin
            @(negedge clk);
            if (u_if.resp_timeout !== 1'b0) bad++;
        end
        n_checks++; if (bad == 0) n_pass++; else $display("FAIL timeout_disabled: %0d cycles set expected 0", bad);
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_tx();
        test_rx();
        test_full_duplex();
        test_reset_mid();
        test_timeout();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/remote_comm.md
# remote_comm

Host-side command link for the Knight's Tour robot. Takes a 16-bit host command and a single-cycle `send_cmd` strobe, and serialises the command over UART as two bytes, high byte first. It also receives the robot's 8-bit response bytes (`8'hA5` positive acknowledge, `8'h5A` tour started) and presents them with a `resp_rdy` flag. It sits directly between the bench's command/response tasks and the DUT's `RX`/`TX` pins.

## Interface
- `BAUD_DIV`, default 5208: clock cycles per UART bit (50 MHz / 9600 baud); minimum 8.
- `RESP_TIMEOUT`, default 24'hFF_FFFF: cycles allowed from `cmd_sent` to the first response byte; used only with the timeout feature.

Ports:
- `clk` in 1: system clock.
- `RST_n` in 1: reset; one clock, synchronous, active-low.
- `cmd` in 16: command word, sampled on the cycle `send_cmd` is accepted.
- `send_cmd` in 1: request strobe.
- `cmd_sent` out 1: one-cycle pulse after the low byte's stop bit completes.
- `busy` out 1: high while a command is in transmission.
- `TX` out 1: serial data to the DUT; idles high.
- `RX` in 1: serial data from the DUT; asynchronous.
- `resp` out 8: last good received byte.
- `resp_rdy` out 1: level flag, set when a good byte arrives.
- `resp_timeout` out 1: sticky timeout flag.

## Operation
- TX FSM states: IDLE, LOAD_H, SEND_H, LOAD_L, SEND_L, DONE.
  - IDLE → LOAD_H: `send_cmd`=1. `cmd` is captured in the same cycle.
  - LOAD_H → SEND_H: after 1 cycle.
  - SEND_H → LOAD_L: after the 10-bit frame completes.
  - LOAD_L → SEND_L: after 1 cycle.
  - SEND_L → DONE: after the frame completes.
  - DONE → IDLE: after 1 cycle, with `cmd_sent`=1.
- Frame format: start bit 0, 8 data bits LSB first, stop bit 1. Each bit is held exactly `BAUD_DIV` cycles by a down-counter.
- `busy`=1 in every state except IDLE.
- `send_cmd` while `busy`: ignored. No queuing, captured command unchanged.
- RX input path:
  - `RX` passes through a 2-flop synchronizer, preset to 1 on reset.
  - A falling edge in RX_IDLE starts reception.
  - Samples are taken at `BAUD_DIV/2`, then every `BAUD_DIV` cycles, 10 samples in total.
- RX error handling:
  - Start-bit sample = 1: false start, return to RX_IDLE with no output.
  - Stop-bit sample = 0: framing error, byte discarded, `resp`/`resp_rdy` unchanged.
- Good byte: `resp` is loaded and `resp_rdy` is set in the same cycle.
- `resp_rdy` clears on:
  - acceptance of a new `send_cmd`, or
  - detection of the next start bit.
  - If both events occur in the same cycle, the result is the same: cleared.
- RX and TX are fully independent; full-duplex operation is legal.
- Reset mid-operation, on the next edge:
  - `TX`=1;
  - both FSMs return to idle;
  - partial frames are lost;
  - the remote side sees a truncated frame.

## Timing
- Reset values: `TX`=1, `busy`=0, `cmd_sent`=0, `resp`=8'h00, `resp_rdy`=0, `resp_timeout`=0.
- TX latency: `send_cmd` accepted at edge N; `TX` is registered low at edge N+2.
- `cmd_sent` is high for the cycle following edge N+20·`BAUD_DIV`+3. There is one idle cycle between frames (the LOAD_L state).
- `send_cmd` is accepted again at the edge where `cmd_sent` is high.
- RX latency: `resp_rdy` rises 2 (synchronizer) + 1 + 9.5·`BAUD_DIV` cycles after the `RX` falling edge, ±1 cycle.
- Counter widths: bit counter 4 bits; baud counter `$clog2(BAUD_DIV)`+1 bits; timeout counter 24 bits. No wrap is possible within a frame.

## Configuration
- Macro: `REMOTE_COMM_RESP_TIMEOUT_EN`.
- When defined:
  - a counter clears and starts at `cmd_sent`;
  - it stops when `resp_rdy` rises;
  - if it reaches `RESP_TIMEOUT`, `resp_timeout` is set;
  - `resp_timeout` stays set until the next accepted `send_cmd`.
- When undefined: the counter logic is absent and `resp_timeout` is tied to 0.

## Test plan
All scenarios use `BAUD_DIV`=16.
1. Reset: hold `RST_n`=0 for 2 clocks → `TX`=1, `busy`=0, `resp`=8'h00, `resp_rdy`=0, `cmd_sent`=0; `TX` stays 1 for 100 cycles after release.
2. `cmd`=16'h2A5F with a `send_cmd` pulse → `TX` shows frame 0x2A, then frame 0x5F (bits LSB first, 16 cycles each); `cmd_sent` pulses exactly 323 cycles after acceptance; `busy` falls together with it.
3. During scenario 2, pulse `send_cmd` with `cmd`=16'hFFFF at cycle 50 → ignored; the waveform on `TX` is unchanged.
4. Drive `RX` with byte 8'hA5, then 8'h5A → `resp`=8'hA5 with `resp_rdy` rising; `resp_rdy` clears at the second start bit, then `resp`=8'h5A with `resp_rdy` high again.
5. Drive `RX` with 8'h3C but stop bit = 0 → `resp_rdy` stays 0 and `resp` is unchanged. A 4-cycle low glitch on `RX` → no byte is received.
6. With `REMOTE_COMM_RESP_TIMEOUT_EN` and `RESP_TIMEOUT`=1000, send a command with no reply → `resp_timeout`=1 at 1000 cycles after `cmd_sent`. The next `send_cmd` clears it. A reply arriving within 500 cycles → `resp_timeout` stays 0.
